// File: rtl/acq_adc_gate_if.sv
// Sample stream bundle (data + strobe) shared by the raw ADC input and the gated output.
// The master drives data/valid and the slave receives them.
interface acq_adc_gate_if #(
  parameter int unsigned W = 8
);
  logic [W-1:0] data;
  logic         valid;

  modport master (output data, output valid);
  modport slave  (input  data, input  valid);
endinterface

// File: rtl/acq_adc_gate.sv
// Epoch-aligned ADC capture gate with optional integrate-and-dump decimation.
// Emits length-bounded blocks of 2-bit samples to the acquisition core.
module acq_adc_gate #(
  parameter int unsigned PORTS   = 4,
  parameter int unsigned R       = 2,
  parameter int unsigned DECIM_W = 8,
  parameter int unsigned LEN_W   = 20
) (
  input  logic               adc_clk,
  input  logic               rst,
  acq_adc_gate_if.slave      adc_in,
  acq_adc_gate_if.master     adc_out,
  input  logic               arm,
  input  logic               epoch,
  input  logic [DECIM_W-1:0] decim,
  input  logic [LEN_W-1:0]   len,
  output logic               busy,
  output logic               done
);

  localparam int unsigned DW = PORTS * R;
  // Accumulator holds up to (2^DECIM_W-1) samples of magnitude 3, plus sign.
  localparam int unsigned AW = $clog2(3 * (2**DECIM_W - 1)) + 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  state_t                state;
  logic [DECIM_W-1:0]    decim_l;
  logic [LEN_W-1:0]      len_l;
  logic [LEN_W-1:0]      out_cnt;
  logic [DECIM_W-1:0]    grp_cnt;
  logic signed [AW-1:0]  acc [PORTS];

  logic                  accept_c;
  logic                  bypass_c;
  logic                  last_c;
  logic                  strobe_c;
  logic                  final_c;
  logic [AW-1:0]         thr_c;
  logic signed [AW-1:0]  acc_sum_c [PORTS];
  logic [AW-1:0]         mag_c [PORTS];
  logic [DW-1:0]         dec_code_c;

  // Map a {sign, magnitude} code onto its signed level: +-1 or +-3.
  function automatic logic signed [AW-1:0] samp_val(input logic [R-1:0] code);
    logic signed [AW-1:0] v;
    v = code[0] ? AW'(3) : AW'(1);
    return code[1] ? -v : v;
  endfunction

  // Acceptance, group boundary and re-quantisation of the running sums.
  always_comb begin
    accept_c   = (state == ST_CAPTURE) && adc_in.valid;
    bypass_c   = (decim_l <= DECIM_W'(1));
    last_c     = (grp_cnt == decim_l - DECIM_W'(1));
    strobe_c   = accept_c && (bypass_c || last_c);
    final_c    = strobe_c && ((out_cnt + LEN_W'(1)) == len_l);
    thr_c      = AW'({decim_l, 1'b0});
    dec_code_c = '0;
    for (int p = 0; p < PORTS; p++) begin
      acc_sum_c[p] = acc[p] + samp_val(adc_in.data[p*R +: R]);
      mag_c[p]     = acc_sum_c[p][AW-1] ? AW'(-acc_sum_c[p]) : AW'(acc_sum_c[p]);
      dec_code_c[p*R +: R] = R'({acc_sum_c[p][AW-1], (mag_c[p] >= thr_c)});
    end
  end

  // Control FSM with registered outputs and datapath state.
  always_ff @(posedge adc_clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      decim_l       <= '0;
      len_l         <= '0;
      out_cnt       <= '0;
      grp_cnt       <= '0;
      adc_out.data  <= '0;
      adc_out.valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      for (int p = 0; p < PORTS; p++) acc[p] <= '0;
    end else begin
      adc_out.valid <= 1'b0;
      done          <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arm) begin
            decim_l <= decim;
            len_l   <= len;
            out_cnt <= '0;
            grp_cnt <= '0;
            for (int p = 0; p < PORTS; p++) acc[p] <= '0;
            state   <= ST_ARMED;
            busy    <= 1'b1;
          end
        end
        ST_ARMED: begin
          // A repeated arm takes precedence and restarts the wait for epoch.
          if (arm) begin
            decim_l <= decim;
            len_l   <= len;
            out_cnt <= '0;
            grp_cnt <= '0;
            for (int p = 0; p < PORTS; p++) acc[p] <= '0;
          end else if (epoch) begin
            if (len_l == '0) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= ST_CAPTURE;
            end
          end
        end
        ST_CAPTURE: begin
          if (accept_c) begin
            if (bypass_c) begin
              adc_out.data <= adc_in.data;
            end else if (last_c) begin
              adc_out.data <= dec_code_c;
              grp_cnt      <= '0;
              for (int p = 0; p < PORTS; p++) acc[p] <= '0;
            end else begin
              grp_cnt <= grp_cnt + DECIM_W'(1);
              for (int p = 0; p < PORTS; p++) acc[p] <= acc_sum_c[p];
            end
          end
          if (strobe_c) begin
            adc_out.valid <= 1'b1;
            out_cnt       <= out_cnt + LEN_W'(1);
          end
          if (final_c) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acq_adc_gate.sv
// Scoreboard bench for acq_adc_gate: directed captures, expected samples queued
// by the stimulus and checked by an independent output monitor.
module tb_acq_adc_gate;

  logic        adc_clk;
  logic        rst;
  logic        arm;
  logic        epoch;
  logic [7:0]  decim;
  logic [19:0] len;
  logic        busy;
  logic        done;

  acq_adc_gate_if #(.W(8)) in_if ();
  acq_adc_gate_if #(.W(8)) out_if ();

  acq_adc_gate dut (
    .adc_clk (adc_clk),
    .rst     (rst),
    .adc_in  (in_if),
    .adc_out (out_if),
    .arm     (arm),
    .epoch   (epoch),
    .decim   (decim),
    .len     (len),
    .busy    (busy),
    .done    (done)
  );

  int         checks;
  int         errors;
  int         done_pending;
  logic [7:0] exp_q [$];

  initial adc_clk = 1'b0;
  always #5 adc_clk = ~adc_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge adc_clk);
    #1;
  endtask

  task automatic do_arm(input logic [7:0] d, input logic [19:0] l);
    arm = 1'b1; decim = d; len = l;
    tick();
    arm = 1'b0;
  endtask

  task automatic do_epoch();
    epoch = 1'b1;
    tick();
    epoch = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    in_if.valid = 1'b1; in_if.data = d;
    tick();
    in_if.valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Output monitor: every strobe must match the head of the scoreboard.
  always @(negedge adc_clk) begin
    if (!rst) begin
      if (out_if.valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got data %h, required no output", out_if.data);
        end else begin
          chk("out_data", 32'(out_if.data), 32'(exp_q.pop_front()));
        end
      end
      if (done) begin
        chk("done_expected", 32'(done_pending > 0), 32'd1);
        if (done_pending > 0) done_pending--;
        chk("done_after_last_sample", 32'(exp_q.size()), 32'd0);
        chk("busy_clear_at_done", 32'(busy), 32'd0);
      end
    end
  end

  logic [7:0] t1 [8];

  initial begin
    checks = 0; errors = 0; done_pending = 0;
    rst = 1'b1; arm = 1'b0; epoch = 1'b0; decim = '0; len = '0;
    in_if.valid = 1'b0; in_if.data = '0;
    t1 = '{8'hE4, 8'h1B, 8'h3C, 8'hA5, 8'h5A, 8'h0F, 8'hF0, 8'h99};
    #23;
    chk("rst_valid", 32'(out_if.valid), 32'd0);
    chk("rst_data",  32'(out_if.data),  32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    rst = 1'b0;
    idle(2);

    // 1: bypass, len=5, eight continuous inputs
    do_arm(8'd1, 20'd5);
    chk("t1_busy_armed", 32'(busy), 32'd1);
    do_epoch();
    for (int i = 0; i < 5; i++) exp_q.push_back(t1[i]);
    done_pending++;
    for (int i = 0; i < 8; i++) send(t1[i]);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_done_end", 32'(done), 32'd0);
    idle(3);

    // 2: decim=4, three level patterns
    do_arm(8'd4, 20'd2); do_epoch();
    exp_q.push_back(8'h55); exp_q.push_back(8'h55); done_pending++;
    for (int i = 0; i < 8; i++) send(8'h55);
    idle(3);
    do_arm(8'd4, 20'd2); do_epoch();
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); done_pending++;
    for (int i = 0; i < 8; i++) send(8'h00);
    idle(3);
    do_arm(8'd4, 20'd2); do_epoch();
    exp_q.push_back(8'hFF); exp_q.push_back(8'hFF); done_pending++;
    for (int i = 0; i < 8; i++) send(8'hFF);
    idle(3);

    // 3: decim=2, mixed signs and exact-threshold sum
    do_arm(8'd2, 20'd3); do_epoch();
    exp_q.push_back(8'h08); exp_q.push_back(8'hFF); exp_q.push_back(8'h01);
    done_pending++;
    send(8'h41); send(8'hEE);
    send(8'hFF); send(8'hFF);
    send(8'h01); send(8'h00);
    idle(3);

    // 4: stray epoch, then arm+epoch together must not start capture
    do_epoch();
    chk("t4_busy_after_stray_epoch", 32'(busy), 32'd0);
    arm = 1'b1; epoch = 1'b1; decim = 8'd0; len = 20'd3;
    tick();
    arm = 1'b0; epoch = 1'b0;
    chk("t4_busy_armed", 32'(busy), 32'd1);
    send(8'h11); send(8'h22); send(8'h33);
    idle(2);
    chk("t4_still_armed", 32'(busy), 32'd1);
    do_epoch();
    exp_q.push_back(8'hC3); exp_q.push_back(8'h3C); exp_q.push_back(8'h7E);
    done_pending++;
    send(8'hC3); send(8'h3C); send(8'h7E);
    idle(3);

    // 5: zero-length capture
    do_arm(8'd1, 20'd0);
    done_pending++;
    do_epoch();
    chk("t5_done_after_epoch", 32'(done), 32'd1);
    send(8'hAA);
    idle(3);

    // 6: reset mid-capture, then a full capture with input gaps
    do_arm(8'd1, 20'd10); do_epoch();
    exp_q.push_back(8'h21); exp_q.push_back(8'h38); exp_q.push_back(8'h4F);
    send(8'h21); send(8'h38); send(8'h4F);
    @(negedge adc_clk);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(out_if.valid), 32'd0);
    chk("t6_rst_data",  32'(out_if.data),  32'd0);
    chk("t6_rst_busy",  32'(busy), 32'd0);
    chk("t6_rst_done",  32'(done), 32'd0);
    chk("t6_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    tick();
    #2 rst = 1'b0;
    idle(2);
    do_arm(8'd1, 20'd10); do_epoch();
    done_pending++;
    for (int i = 0; i < 12; i++) begin
      logic [7:0] d;
      d = 8'(i * 23 + 33);
      if (i < 10) exp_q.push_back(d);
      send(d);
      if (i % 3 == 1) idle(2);
    end

    for (int i = 0; i < 20 && (exp_q.size() != 0 || done_pending != 0); i++) tick();
    idle(2);
    chk("final_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("final_done_drained",  32'(done_pending), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
